ram_port_arbiter: RTL and testbench
===================================

// Module: ram_port_arbiter
// PURPOSE
//  Shares one port of the synchronous write-first dual-port RAM among NUM_REQ requesters
//  (e.g. instruction fetch, LSU, debug loader) using a valid/ready request channel and a
//  fixed-latency response channel. Partial-word stores (byte strobes) run as a 2-cycle
//  read-modify-write sequence, because the RAM port has no byte enables.
//  Sits between the core's memory requesters and the RAM port (addr/data/we/q).
// PARAMETERS
//  NUM_REQ     2   number of requesters (1..8)
//  ADDR_WIDTH  16  RAM word address width (RAM DEPTH = 2**ADDR_WIDTH)
//  DATA_WIDTH  32  word width; multiple of 8; NB = DATA_WIDTH/8 byte lanes
// PORTS
//  i_clk        in   1                    clock
//  i_rst        in   1                    synchronous reset, active high
//  i_req_valid  in   NUM_REQ              request valid, one bit per requester
//  o_req_ready  out  NUM_REQ              request accepted this cycle (one-hot or zero)
//  i_req_we     in   NUM_REQ              1 = write, 0 = read
//  i_req_addr   in   NUM_REQ*ADDR_WIDTH   word address, requester r at [r*ADDR_WIDTH +: ADDR_WIDTH]
//  i_req_wdata  in   NUM_REQ*DATA_WIDTH   write data, packed the same way
//  i_req_wstrb  in   NUM_REQ*NB           byte strobes, packed the same way
//  o_rsp_valid  out  NUM_REQ              response strobe (one-hot or zero)
//  o_rsp_rdata  out  DATA_WIDTH           read data, or the final written word for writes
//  o_ram_addr   out  ADDR_WIDTH           to RAM i_addr_x
//  o_ram_data   out  DATA_WIDTH           to RAM i_data_x
//  o_ram_we     out  1                    to RAM i_we_x
//  i_ram_data   in   DATA_WIDTH           from RAM o_data_x (1-cycle latency)
// BEHAVIOUR
//  - Reset: state = IDLE, round-robin pointer = 0, pending response cleared.
//    Outputs while i_rst is high: o_req_ready = 0, o_rsp_valid = 0, o_ram_we = 0.
//    o_ram_addr, o_ram_data and o_rsp_rdata are don't-care during reset.
//  - FSM states: IDLE and RMW.
//  - IDLE: grant one valid requester g. The grant is combinational and o_req_ready[g] = 1
//    in the same cycle T.
//    - Read: RAM addr = addr[g], we = 0.
//      At T+1: o_rsp_valid[g] = 1 and o_rsp_rdata = i_ram_data.
//    - Full write (wstrb all 1): RAM addr/data/we driven at T.
//      At T+1: o_rsp_valid[g] = 1 and o_rsp_rdata = wdata.
//    - Zero-strobe write: no RAM write; response at T+1 with rdata = wdata.
//    - Partial write (strobes mixed): RAM read issued at T; latch addr, wdata, wstrb and
//      owner; go to RMW.
//  - RMW (cycle T+1): grant nothing, o_req_ready = 0.
//    - Write merged word: byte b = wstrb[b] ? wdata byte b : i_ram_data byte b, we = 1.
//    - At T+2: o_rsp_valid[owner] = 1 with the merged word. Return to IDLE.
//  - Throughput: one read or full write per cycle, back to back. A partial write costs
//    2 cycles. A response at T+1 may coincide with a new grant at T+1.
//  - Requesters hold addr/wdata/we/wstrb stable while valid && !ready.
//    The response channel has no backpressure.
//  - Reset mid-RMW: the write is abandoned (no RAM write, no response) and state = IDLE.
//  - A requester dropping valid before ready is legal and generates nothing.
// CONFIGURATION
//  - `MEM_ARB_ROUND_ROBIN_EN defined: round-robin arbitration.
//    - Search starts at pointer p; after each grant g, p = (g+1) mod NUM_REQ.
//    - The pointer does not move in cycles without a grant.
//  - Undefined: fixed priority; the lowest index wins. The pointer register is not built.
// STRUCTURE
//  - Package mem_arb_pkg: arb_state_e {ARB_IDLE, ARB_RMW}; localparam function
//    byte_merge(old, new, strb).
//  - One sub-module, mem_arb_grant: request vector (+ pointer) in, one-hot grant out,
//    purely combinational. Round-robin vs fixed priority is selected by the macro.
//  - The top level holds the FSM, RMW latches, pending-response register and RAM muxing.
// TESTING
//  - RAM[0x0010] = 0xDEADBEEF; req0 reads 0x0010
//    -> ready[0] at T; rsp_valid[0] at T+1 with rdata 0xDEADBEEF.
//  - RAM[0x0020] = 0x11223344; req1 writes 0xAABBCCDD with wstrb 4'b0101
//    -> RAM we at T+1 with data 0x11BB33DD; rsp_valid[1] at T+2; no ready at T+1.
//  - req0 and req1 both reading for 4 cycles
//    -> with RR_EN, grants 0,1,0,1; without it, grants 0,0,0,0.
//  - req0 reads addresses 0..3 back to back -> 4 consecutive rsp_valid[0] pulses, in order.
//  - Partial write with i_rst asserted at T+1
//    -> o_ram_we = 0 at T+1, no rsp at T+2, RAM word unchanged, FSM in IDLE.
//  - Write with wstrb 0 to 0x0030 -> o_ram_we never 1; rsp_valid at T+1; RAM unchanged.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// ----------------------------------------------------------------------------
// mem_arb_pkg
//   Shared types and helpers for the RAM port arbiter.
//   - arb_state_e : arbiter FSM states (idle / read-modify-write).
//   - byte_merge  : merges one byte lane of a store into the old RAM word.
// Configuration macro used by the files importing this package:
//   MEM_ARB_ROUND_ROBIN_EN  (defined: round-robin, undefined: fixed priority)
// ----------------------------------------------------------------------------
package mem_arb_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_RMW  = 1'b1
    } arb_state_e;

    localparam int BYTE_W = 8;

    // One byte lane of a partial store: the strobe picks the new byte,
    // otherwise the byte already in the RAM word survives.
    function automatic logic [BYTE_W-1:0] byte_merge(
        input logic [BYTE_W-1:0] old_byte,
        input logic [BYTE_W-1:0] new_byte,
        input logic              strb
    );
        return strb ? new_byte : old_byte;
    endfunction

endpackage

// File: rtl/mem_arb_grant.sv
// ----------------------------------------------------------------------------
// mem_arb_grant
//   Purely combinational grant selection for the RAM port arbiter.
//   MEM_ARB_ROUND_ROBIN_EN defined : search starts at ptr and wraps around.
//   MEM_ARB_ROUND_ROBIN_EN undefined: lowest requesting index wins, no ptr port.
// Ports
//   req  in   NUM_REQ  requests eligible for a grant this cycle
//   ptr  in   IDX_W    round-robin start index (round-robin build only)
//   gnt  out  NUM_REQ  one-hot grant, zero when nothing requests
// ----------------------------------------------------------------------------
module mem_arb_grant #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
`ifdef MEM_ARB_ROUND_ROBIN_EN
    input  logic [IDX_W-1:0]   ptr,
`endif
    output logic [NUM_REQ-1:0] gnt
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Walk the requesters starting at ptr; the index is reduced modulo
    // NUM_REQ by a single subtraction since ptr < NUM_REQ.
    always_comb begin
        int                 pos;
        logic [IDX_W-1:0]   idx;
        logic               found;
        gnt   = '0;
        found = 1'b0;
        pos   = 0;
        idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pos = int'(ptr) + i;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            idx = IDX_W'(pos);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end
`else
    always_comb begin
        logic found;
        gnt   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req[i]) begin
                gnt[i] = 1'b1;
                found  = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/ram_port_arbiter.sv
// ----------------------------------------------------------------------------
// ram_port_arbiter
//   Shares one port of a synchronous write-first RAM (1-cycle read latency)
//   among NUM_REQ requesters. Requests use valid/ready; responses come back
//   one cycle after the grant (two cycles for partial-word stores, which run
//   as read-modify-write because the RAM port has no byte enables).
// Configuration
//   MEM_ARB_ROUND_ROBIN_EN defined: round-robin arbitration with a pointer
//   that moves to (grant+1) mod NUM_REQ after each grant.
//   Undefined: fixed priority, lowest index wins.
// Ports
//   i_clk        in   1                   clock
//   i_rst        in   1                   synchronous reset, active high
//   i_req_valid  in   NUM_REQ             request valid per requester
//   o_req_ready  out  NUM_REQ             request accepted (one-hot or zero)
//   i_req_we     in   NUM_REQ             1 = write, 0 = read
//   i_req_addr   in   NUM_REQ*ADDR_WIDTH  word address per requester
//   i_req_wdata  in   NUM_REQ*DATA_WIDTH  write data per requester
//   i_req_wstrb  in   NUM_REQ*NB          byte strobes per requester
//   o_rsp_valid  out  NUM_REQ             response strobe (one-hot or zero)
//   o_rsp_rdata  out  DATA_WIDTH          read data, or final written word
//   o_ram_addr   out  ADDR_WIDTH          RAM address
//   o_ram_data   out  DATA_WIDTH          RAM write data
//   o_ram_we     out  1                   RAM write enable
//   i_ram_data   in   DATA_WIDTH          RAM read data (1-cycle latency)
// ----------------------------------------------------------------------------
module ram_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [NUM_REQ-1:0]            i_req_valid,
    output logic [NUM_REQ-1:0]            o_req_ready,
    input  logic [NUM_REQ-1:0]            i_req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_wdata,
    input  logic [NUM_REQ*(DATA_WIDTH/8)-1:0] i_req_wstrb,
    output logic [NUM_REQ-1:0]            o_rsp_valid,
    output logic [DATA_WIDTH-1:0]         o_rsp_rdata,
    output logic [ADDR_WIDTH-1:0]         o_ram_addr,
    output logic [DATA_WIDTH-1:0]         o_ram_data,
    output logic                          o_ram_we,
    input  logic [DATA_WIDTH-1:0]         i_ram_data
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_e state_q, state_d;

    logic [NUM_REQ-1:0]    arb_req;
    logic [NUM_REQ-1:0]    arb_gnt;
    logic                  any_gnt;

    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic [NB-1:0]         sel_strb;

    logic [NUM_REQ-1:0]    rsp_vld_d,  rsp_vld_p1;
    logic                  rsp_ram_d,  rsp_ram_p1;
    logic [DATA_WIDTH-1:0] rsp_word_d, rsp_word_p1;

    logic                  rmw_load;
    logic [ADDR_WIDTH-1:0] rmw_addr_p1;
    logic [DATA_WIDTH-1:0] rmw_wdata_p1;
    logic [NB-1:0]         rmw_strb_p1;
    logic [NUM_REQ-1:0]    rmw_owner_p1;
    logic [DATA_WIDTH-1:0] merged_word;

    // Only an idle, out-of-reset arbiter may grant anything.
    assign arb_req = (state_q == ARB_IDLE && !i_rst) ? i_req_valid : '0;
    assign any_gnt = |arb_gnt;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0] rr_ptr_q;
    logic [IDX_W-1:0] gnt_idx;

    mem_arb_grant #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_grant (
        .req (arb_req),
        .ptr (rr_ptr_q),
        .gnt (arb_gnt)
    );

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_gnt[i]) begin
                gnt_idx = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rr_ptr_q <= '0;
        end else if (any_gnt) begin
            rr_ptr_q <= (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
        end
    end
`else
    mem_arb_grant #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_grant (
        .req (arb_req),
        .gnt (arb_gnt)
    );
`endif

    // Route the granted requester's fields; all zero when nothing is granted.
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_strb  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_gnt[i]) begin
                sel_we    = i_req_we[i];
                sel_addr  = i_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = i_req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                sel_strb  = i_req_wstrb[i*NB +: NB];
            end
        end
    end

    // Old word arrives from the RAM read issued in the grant cycle.
    always_comb begin
        merged_word = '0;
        for (int b = 0; b < NB; b++) begin
            merged_word[b*BYTE_W +: BYTE_W] = byte_merge(i_ram_data[b*BYTE_W +: BYTE_W],
                                                         rmw_wdata_p1[b*BYTE_W +: BYTE_W],
                                                         rmw_strb_p1[b]);
        end
    end

    always_comb begin
        state_d    = state_q;
        rsp_vld_d  = '0;
        rsp_ram_d  = 1'b0;
        rsp_word_d = sel_wdata;
        rmw_load   = 1'b0;
        o_ram_addr = sel_addr;
        o_ram_data = sel_wdata;
        o_ram_we   = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (any_gnt) begin
                    if (!sel_we) begin
                        rsp_vld_d = arb_gnt;
                        rsp_ram_d = 1'b1;
                    end else if (&sel_strb) begin
                        rsp_vld_d = arb_gnt;
                        o_ram_we  = 1'b1;
                    end else if (!(|sel_strb)) begin
                        // Nothing to store: echo the data without touching the RAM.
                        rsp_vld_d = arb_gnt;
                    end else begin
                        // Mixed strobes: this cycle's RAM access is the read half.
                        rmw_load = 1'b1;
                        state_d  = ARB_RMW;
                    end
                end
            end
            ARB_RMW: begin
                o_ram_addr = rmw_addr_p1;
                o_ram_data = merged_word;
                o_ram_we   = 1'b1;
                rsp_vld_d  = rmw_owner_p1;
                rsp_word_d = merged_word;
                state_d    = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
        // Reset abandons a pending RMW write.
        if (i_rst) begin
            o_ram_we = 1'b0;
        end
    end

    // ---- stage boundary: grant / RMW cycle -> response cycle ----
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= ARB_IDLE;
            rsp_vld_p1 <= '0;
        end else begin
            state_q    <= state_d;
            rsp_vld_p1 <= rsp_vld_d;
        end
    end

    always_ff @(posedge i_clk) begin
        rsp_ram_p1  <= rsp_ram_d;
        rsp_word_p1 <= rsp_word_d;
        if (rmw_load) begin
            rmw_addr_p1  <= sel_addr;
            rmw_wdata_p1 <= sel_wdata;
            rmw_strb_p1  <= sel_strb;
            rmw_owner_p1 <= arb_gnt;
        end
    end

    assign o_req_ready = arb_gnt;
    assign o_rsp_valid = i_rst ? '0 : rsp_vld_p1;
    // Reads return the RAM output directly; writes return the stored word.
    assign o_rsp_rdata = rsp_ram_p1 ? i_ram_data : rsp_word_p1;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ram_port_arbiter
//   Bench for ram_port_arbiter (NUM_REQ=2, 16-bit address, 32-bit data) with a
//   write-first RAM model. Directed vector table, hand-written multi-cycle
//   sequences, then randomized traffic against a transaction-level model.
//   Build with or without MEM_ARB_ROUND_ROBIN_EN to match the RTL build.
// ----------------------------------------------------------------------------
module tb_ram_port_arbiter;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int NB = 4;
    localparam int NRAND = 1500;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic            i_clk = 1'b0;
    logic            i_rst;
    logic [1:0]      i_req_valid, o_req_ready, i_req_we, o_rsp_valid;
    logic [2*AW-1:0] i_req_addr;
    logic [2*DW-1:0] i_req_wdata;
    logic [2*NB-1:0] i_req_wstrb;
    logic [DW-1:0]   o_rsp_rdata, o_ram_data, i_ram_data;
    logic [AW-1:0]   o_ram_addr;
    logic            o_ram_we;

    logic            rv  [2];
    logic            rwe [2];
    logic [AW-1:0]   ra  [2];
    logic [DW-1:0]   rd  [2];
    logic [NB-1:0]   rs  [2];

    assign i_req_valid = {rv[1], rv[0]};
    assign i_req_we    = {rwe[1], rwe[0]};
    assign i_req_addr  = {ra[1], ra[0]};
    assign i_req_wdata = {rd[1], rd[0]};
    assign i_req_wstrb = {rs[1], rs[0]};

    always #5 i_clk = ~i_clk;

    ram_port_arbiter #(
        .NUM_REQ    (2),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_req_valid (i_req_valid),
        .o_req_ready (o_req_ready),
        .i_req_we    (i_req_we),
        .i_req_addr  (i_req_addr),
        .i_req_wdata (i_req_wdata),
        .i_req_wstrb (i_req_wstrb),
        .o_rsp_valid (o_rsp_valid),
        .o_rsp_rdata (o_rsp_rdata),
        .o_ram_addr  (o_ram_addr),
        .o_ram_data  (o_ram_data),
        .o_ram_we    (o_ram_we),
        .i_ram_data  (i_ram_data)
    );

    // Write-first RAM with a backdoor preload port used only while the DUT is idle.
    logic [DW-1:0] mem [0:65535];
    logic          bd_we;
    logic [AW-1:0] bd_addr;
    logic [DW-1:0] bd_data;

    always @(posedge i_clk) begin
        if (bd_we) mem[bd_addr] <= bd_data;
        else if (o_ram_we) mem[o_ram_addr] <= o_ram_data;
        i_ram_data <= o_ram_we ? o_ram_data : mem[o_ram_addr];
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle_inputs();
        for (int r = 0; r < 2; r++) begin
            rv[r] = 1'b0; rwe[r] = 1'b0; ra[r] = '0; rd[r] = '0; rs[r] = '0;
        end
    endtask

    task automatic bd_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bd_we = 1'b1; bd_addr = a; bd_data = d;
        tick();
        bd_we = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        i_rst = 1'b1;
        tick();
        tick();
        i_rst = 1'b0;
    endtask

    task automatic drive(input int r, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [NB-1:0] s);
        rv[r] = 1'b1; rwe[r] = we; ra[r] = a; rd[r] = d; rs[r] = s;
    endtask

    task automatic new_req(input int r);
        rv[r]  = ($urandom % 4) != 0;
        rwe[r] = $urandom % 2;
        ra[r]  = 16'h0100 + AW'($urandom % 16);
        rd[r]  = $urandom;
        case ($urandom % 4)
            0:       rs[r] = 4'hF;
            1:       rs[r] = 4'h0;
            default: rs[r] = 4'($urandom);
        endcase
    endtask

    typedef struct {
        logic [1:0] valid;
        logic [1:0] we;
        logic [3:0] strb0;
        logic [3:0] strb1;
        logic [1:0] rdy_fp;
        logic       we_fp;
        logic [1:0] rdy_rr;
        logic       we_rr;
    } vec_t;

    vec_t tbl [8];

    // Reference model state for the randomized phase
    logic [DW-1:0] ref_mem [16];
    logic [DW-1:0] dval [4];

    initial begin
        logic [1:0]    exp_prev;
        logic [1:0]    e_rdy;
        logic          e_we;
        int            g, ptr, j, k;
        logic          busy, busy_next;
        logic          s1_v, s2_v, cur_v;
        int            s1_o, s2_o, cur_o;
        logic [DW-1:0] s1_d, s2_d, cur_d, oldw, neww, mask;
        logic [1:0]    e_rsp;

        tbl[0] = '{2'b00, 2'b00, 4'hF, 4'hF, 2'b00, 1'b0, 2'b00, 1'b0};
        tbl[1] = '{2'b01, 2'b00, 4'hF, 4'hF, 2'b01, 1'b0, 2'b01, 1'b0};
        tbl[2] = '{2'b11, 2'b00, 4'hF, 4'hF, 2'b01, 1'b0, 2'b10, 1'b0};
        tbl[3] = '{2'b10, 2'b00, 4'hF, 4'hF, 2'b10, 1'b0, 2'b10, 1'b0};
        tbl[4] = '{2'b11, 2'b11, 4'hF, 4'hF, 2'b01, 1'b1, 2'b01, 1'b1};
        tbl[5] = '{2'b11, 2'b11, 4'hF, 4'hF, 2'b01, 1'b1, 2'b10, 1'b1};
        tbl[6] = '{2'b01, 2'b01, 4'h0, 4'hF, 2'b01, 1'b0, 2'b01, 1'b0};
        tbl[7] = '{2'b11, 2'b10, 4'hF, 4'hF, 2'b01, 1'b0, 2'b10, 1'b1};

        bd_we = 1'b0; bd_addr = '0; bd_data = '0;
        idle_inputs();
        i_rst = 1'b1;
        tick();

        // Reset: requests present but nothing may be granted or written
        drive(0, 1'b1, 16'h0040, 32'h0, 4'hF);
        drive(1, 1'b0, 16'h0041, 32'h0, 4'hF);
        @(negedge i_clk);
        chk("rst_ready", 64'(o_req_ready), 64'(2'b00));
        chk("rst_rsp", 64'(o_rsp_valid), 64'(2'b00));
        chk("rst_ram_we", 64'(o_ram_we), 64'(1'b0));
        tick();
        idle_inputs();
        i_rst = 1'b0;
        tick();

        // Vector table (pointer starts at 0 after reset)
        bd_write(16'h0040, 32'h0000_4040);
        bd_write(16'h0041, 32'h0000_4141);
        do_reset();
        exp_prev = 2'b00;
        for (int i = 0; i < 8; i++) begin
            rv[0] = tbl[i].valid[0]; rv[1] = tbl[i].valid[1];
            rwe[0] = tbl[i].we[0];   rwe[1] = tbl[i].we[1];
            rs[0] = tbl[i].strb0;    rs[1] = tbl[i].strb1;
            ra[0] = 16'h0040;        ra[1] = 16'h0041;
            rd[0] = 32'hC0DE_0000 + 32'(i); rd[1] = 32'hBEEF_0000 + 32'(i);
            e_rdy = RR ? tbl[i].rdy_rr : tbl[i].rdy_fp;
            e_we  = RR ? tbl[i].we_rr  : tbl[i].we_fp;
            @(negedge i_clk);
            chk($sformatf("tbl%0d_ready", i), 64'(o_req_ready), 64'(e_rdy));
            chk($sformatf("tbl%0d_ram_we", i), 64'(o_ram_we), 64'(e_we));
            chk($sformatf("tbl%0d_rsp", i), 64'(o_rsp_valid), 64'(exp_prev));
            exp_prev = e_rdy;
            tick();
        end
        idle_inputs();
        @(negedge i_clk);
        chk("tbl_last_rsp", 64'(o_rsp_valid), 64'(exp_prev));
        tick();

        // Single read
        bd_write(16'h0010, 32'hDEAD_BEEF);
        drive(0, 1'b0, 16'h0010, 32'h0, 4'h0);
        @(negedge i_clk);
        chk("rd_ready", 64'(o_req_ready), 64'(2'b01));
        chk("rd_ram_addr", 64'(o_ram_addr), 64'(16'h0010));
        chk("rd_ram_we", 64'(o_ram_we), 64'(1'b0));
        tick();
        idle_inputs();
        @(negedge i_clk);
        chk("rd_rsp", 64'(o_rsp_valid), 64'(2'b01));
        chk("rd_rdata", 64'(o_rsp_rdata), 64'(32'hDEAD_BEEF));
        tick();

        // Partial write by req1, req0 asks during the RMW cycle
        bd_write(16'h0020, 32'h1122_3344);
        drive(1, 1'b1, 16'h0020, 32'hAABB_CCDD, 4'b0101);
        @(negedge i_clk);
        chk("pw_ready_T", 64'(o_req_ready), 64'(2'b10));
        chk("pw_ram_we_T", 64'(o_ram_we), 64'(1'b0));
        tick();
        idle_inputs();
        drive(0, 1'b0, 16'h0010, 32'h0, 4'h0);
        @(negedge i_clk);
        chk("pw_ready_T1", 64'(o_req_ready), 64'(2'b00));
        chk("pw_ram_we_T1", 64'(o_ram_we), 64'(1'b1));
        chk("pw_ram_addr_T1", 64'(o_ram_addr), 64'(16'h0020));
        chk("pw_ram_data_T1", 64'(o_ram_data), 64'(32'h11BB_33DD));
        chk("pw_rsp_T1", 64'(o_rsp_valid), 64'(2'b00));
        tick();
        @(negedge i_clk);
        chk("pw_rsp_T2", 64'(o_rsp_valid), 64'(2'b10));
        chk("pw_rdata_T2", 64'(o_rsp_rdata), 64'(32'h11BB_33DD));
        chk("pw_ready_T2", 64'(o_req_ready), 64'(2'b01));
        tick();
        idle_inputs();
        @(negedge i_clk);
        chk("pw_next_rsp", 64'(o_rsp_valid), 64'(2'b01));
        chk("pw_next_rdata", 64'(o_rsp_rdata), 64'(32'hDEAD_BEEF));
        chk("pw_mem", 64'(mem[16'h0020]), 64'(32'h11BB_33DD));
        tick();

        // Two readers contending for 4 cycles
        do_reset();
        drive(0, 1'b0, 16'h0010, 32'h0, 4'h0);
        drive(1, 1'b0, 16'h0020, 32'h0, 4'h0);
        for (int c = 0; c < 4; c++) begin
            e_rdy = (RR && (c % 2 == 1)) ? 2'b10 : 2'b01;
            @(negedge i_clk);
            chk($sformatf("arb%0d_ready", c), 64'(o_req_ready), 64'(e_rdy));
            tick();
        end
        idle_inputs();
        tick();

        // Back-to-back reads 0..3
        for (int c = 0; c < 4; c++) begin
            dval[c] = 32'h5A00_0000 + 32'(c * 32'h0101_0101);
            bd_write(AW'(c), dval[c]);
        end
        for (int c = 0; c < 4; c++) begin
            drive(0, 1'b0, AW'(c), 32'h0, 4'h0);
            @(negedge i_clk);
            chk($sformatf("b2b%0d_ready", c), 64'(o_req_ready), 64'(2'b01));
            if (c > 0) begin
                chk($sformatf("b2b%0d_rsp", c), 64'(o_rsp_valid), 64'(2'b01));
                chk($sformatf("b2b%0d_rdata", c), 64'(o_rsp_rdata), 64'(dval[c-1]));
            end
            tick();
        end
        idle_inputs();
        @(negedge i_clk);
        chk("b2b_last_rsp", 64'(o_rsp_valid), 64'(2'b01));
        chk("b2b_last_rdata", 64'(o_rsp_rdata), 64'(dval[3]));
        tick();

        // Partial write abandoned by reset in the RMW cycle
        bd_write(16'h0050, 32'h0102_0304);
        drive(0, 1'b1, 16'h0050, 32'hFFFF_FFFF, 4'b0011);
        @(negedge i_clk);
        chk("rstrmw_ready_T", 64'(o_req_ready), 64'(2'b01));
        tick();
        idle_inputs();
        i_rst = 1'b1;
        @(negedge i_clk);
        chk("rstrmw_ram_we_T1", 64'(o_ram_we), 64'(1'b0));
        chk("rstrmw_rsp_T1", 64'(o_rsp_valid), 64'(2'b00));
        tick();
        i_rst = 1'b0;
        drive(0, 1'b0, 16'h0050, 32'h0, 4'h0);
        @(negedge i_clk);
        chk("rstrmw_rsp_T2", 64'(o_rsp_valid), 64'(2'b00));
        chk("rstrmw_idle_ready", 64'(o_req_ready), 64'(2'b01));
        chk("rstrmw_mem", 64'(mem[16'h0050]), 64'(32'h0102_0304));
        tick();
        idle_inputs();
        @(negedge i_clk);
        chk("rstrmw_rd_rsp", 64'(o_rsp_valid), 64'(2'b01));
        chk("rstrmw_rd_rdata", 64'(o_rsp_rdata), 64'(32'h0102_0304));
        tick();

        // Zero-strobe write
        bd_write(16'h0030, 32'h55AA_55AA);
        drive(0, 1'b1, 16'h0030, 32'h1234_5678, 4'h0);
        @(negedge i_clk);
        chk("zs_ready", 64'(o_req_ready), 64'(2'b01));
        chk("zs_ram_we_T", 64'(o_ram_we), 64'(1'b0));
        tick();
        idle_inputs();
        @(negedge i_clk);
        chk("zs_rsp", 64'(o_rsp_valid), 64'(2'b01));
        chk("zs_rdata", 64'(o_rsp_rdata), 64'(32'h1234_5678));
        chk("zs_ram_we_T1", 64'(o_ram_we), 64'(1'b0));
        tick();
        chk("zs_mem", 64'(mem[16'h0030]), 64'(32'h55AA_55AA));

        // Randomized traffic against a transaction-level model: each grant is
        // applied atomically to ref_mem in grant order, and its response is
        // scheduled 1 cycle later (2 for mixed strobes, which also blocks the
        // next cycle's grant).
        do_reset();
        for (int a = 0; a < 16; a++) begin
            ref_mem[a] = $urandom;
            bd_write(16'h0100 + AW'(a), ref_mem[a]);
        end
        ptr = 0; busy = 1'b0;
        s1_v = 1'b0; s2_v = 1'b0; s1_o = 0; s2_o = 0; s1_d = '0; s2_d = '0;
        new_req(0);
        new_req(1);
        for (int cyc = 0; cyc < NRAND + 3; cyc++) begin
            cur_v = s1_v; cur_o = s1_o; cur_d = s1_d;
            s1_v = s2_v;  s1_o = s2_o;  s1_d = s2_d;
            s2_v = 1'b0;

            g = -1;
            if (!busy) begin
                for (int i = 0; i < 2; i++) begin
                    j = RR ? (ptr + i) % 2 : i;
                    if (g < 0 && rv[j]) g = j;
                end
            end
            e_rdy = 2'b00;
            if (g >= 0) e_rdy[g] = 1'b1;
            e_rsp = 2'b00;
            if (cur_v) e_rsp[cur_o] = 1'b1;

            @(negedge i_clk);
            chk("rnd_ready", 64'(o_req_ready), 64'(e_rdy));
            chk("rnd_rsp", 64'(o_rsp_valid), 64'(e_rsp));
            if (cur_v) chk("rnd_rdata", 64'(o_rsp_rdata), 64'(cur_d));

            busy_next = 1'b0;
            if (g >= 0) begin
                ptr  = (g + 1) % 2;
                k    = int'(ra[g]) - 32'h100;
                oldw = ref_mem[k];
                if (!rwe[g]) begin
                    s1_v = 1'b1; s1_o = g; s1_d = oldw;
                end else begin
                    for (int b = 0; b < NB; b++) mask[b*8 +: 8] = {8{rs[g][b]}};
                    neww = (oldw & ~mask) | (rd[g] & mask);
                    ref_mem[k] = neww;
                    if (rs[g] == 4'hF || rs[g] == 4'h0) begin
                        s1_v = 1'b1; s1_o = g; s1_d = rd[g];
                    end else begin
                        s2_v = 1'b1; s2_o = g; s2_d = neww;
                        busy_next = 1'b1;
                    end
                end
            end
            busy = busy_next;

            tick();
            for (int r = 0; r < 2; r++) begin
                if (!rv[r] || r == g) new_req(r);
                if (cyc >= NRAND - 1) rv[r] = 1'b0;
            end
        end
        idle_inputs();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
